// File: rtl/protocore_pkg.sv
// protocore_pkg: shared definitions for the program-image loader.
//   SYNC_BYTE_DEF : default frame start marker
//   LEN_W         : width of the frame word-count field
//   ld_state_e    : loader FSM state encoding
package protocore_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         LEN_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } ld_state_e;

endpackage

// File: rtl/uart_loader.sv
// uart_loader: parses a framed program image from the UART receive stage
// while the core is halted and writes it word by word into instruction memory.
// Frame: SYNC, LEN_HI, LEN_LO, N*WORD_BYTES data bytes (little-endian), CHK.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   HALT_flag                 : loader runs only while high
//   packet_ready, uart_packet : byte offered by the receive stage
//   packet_ack                : one-cycle pulse consuming the byte
//   mem_we/mem_addr/mem_wdata : instruction memory write port
//   load_busy                 : frame in progress
//   load_done / load_error    : sticky completion status
module uart_loader
    import protocore_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  HALT_flag,
    input  logic                  packet_ready,
    input  logic [7:0]            uart_packet,
    output logic                  packet_ack,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int BIDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam longint unsigned MAX_WORDS = 64'd1 << ADDR_WIDTH;

    ld_state_e state, state_nxt;

    logic                  consume;
    logic                  accept;
    logic [7:0]            len_hi_q;
    logic [LEN_W-1:0]      len_n;
    logic [LEN_W-1:0]      words_left;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [BIDX_W-1:0]     byte_idx;
    logic [DATA_WIDTH-1:0] word_asm;
    logic [DATA_WIDTH-1:0] asm_next;
    logic [7:0]            chk_acc;
    logic                  byte_last;
    logic                  word_last;
    logic                  oversize;

    assign len_n     = {len_hi_q, uart_packet};
    assign byte_last = (byte_idx == BIDX_W'(WORD_BYTES - 1));
    assign word_last = (words_left == LEN_W'(1));
    assign oversize  = (64'(len_n) > MAX_WORDS);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and byte-consume decision
    always_comb begin
        state_nxt = state;
        asm_next  = word_asm;
        asm_next[byte_idx*8 +: 8] = uart_packet;

        // DONE/ERROR are single-cycle; bytes wait for IDLE
        accept  = (state != ST_DONE) && (state != ST_ERROR);
        // gating on !packet_ack keeps the byte under ack from counting twice
        consume = HALT_flag && packet_ready && !packet_ack && accept;

        case (state)
            ST_IDLE:   if (consume && uart_packet == SYNC_BYTE) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (consume) state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (consume) begin
                if (oversize)             state_nxt = ST_ERROR;
                else if (len_n == '0)     state_nxt = ST_CHECK;
                else                      state_nxt = ST_DATA;
            end
            ST_DATA:   if (consume && byte_last && word_last) state_nxt = ST_CHECK;
            ST_CHECK:  if (consume) state_nxt = (uart_packet == chk_acc) ? ST_DONE : ST_ERROR;
            ST_DONE:   state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        // dropping HALT abandons the frame; partial words are lost
        if (!HALT_flag) state_nxt = ST_IDLE;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packet_ack <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            len_hi_q   <= '0;
            words_left <= '0;
            word_addr  <= '0;
            byte_idx   <= '0;
            word_asm   <= '0;
            chk_acc    <= '0;
        end else if (!HALT_flag) begin
            // same as reset, but status flags survive for the control unit
            packet_ack <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_busy  <= 1'b0;
            len_hi_q   <= '0;
            words_left <= '0;
            word_addr  <= '0;
            byte_idx   <= '0;
            word_asm   <= '0;
            chk_acc    <= '0;
        end else begin
            packet_ack <= consume;
            mem_we     <= 1'b0;

            if (consume) begin
                case (state)
                    ST_IDLE: if (uart_packet == SYNC_BYTE) begin
                        chk_acc    <= '0;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        load_busy  <= 1'b1;
                    end
                    ST_LEN_HI: begin
                        len_hi_q <= uart_packet;
                        chk_acc  <= chk_acc ^ uart_packet;
                    end
                    ST_LEN_LO: begin
                        chk_acc    <= chk_acc ^ uart_packet;
                        words_left <= len_n;
                        word_addr  <= '0;
                        byte_idx   <= '0;
                        word_asm   <= '0;
                    end
                    ST_DATA: begin
                        chk_acc <= chk_acc ^ uart_packet;
                        if (byte_last) begin
                            // write lands one cycle after the word's last byte
                            mem_we     <= 1'b1;
                            mem_addr   <= word_addr;
                            mem_wdata  <= asm_next;
                            word_addr  <= word_addr + 1'b1;  // wraps unused on a full image
                            words_left <= words_left - 1'b1;
                            byte_idx   <= '0;
                            word_asm   <= '0;
                        end else begin
                            byte_idx <= byte_idx + BIDX_W'(1);
                            word_asm <= asm_next;
                        end
                    end
                    default: ;
                endcase
            end

            if (state_nxt == ST_DONE) begin
                load_done <= 1'b1;
                load_busy <= 1'b0;
            end
            if (state_nxt == ST_ERROR) begin
                load_error <= 1'b1;
                load_busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        HALT_flag;
    logic        packet_ready;
    logic [7:0]  uart_packet;
    logic        packet_ack;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ack_cnt   = 0;
    int lat_bad   = 0;
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    uart_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .HALT_flag(HALT_flag),
        .packet_ready(packet_ready), .uart_packet(uart_packet),
        .packet_ack(packet_ack), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .load_busy(load_busy),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    // write/ack monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (packet_ack) ack_cnt++;
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            // write must coincide with the ack of the word's final byte
            if (!packet_ack) lat_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        packet_ready = 1'b1;
        uart_packet  = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!packet_ack && n < 20);
        packet_ready = 1'b0;
        if (!packet_ack) begin
            total_cnt++;
            $display("FAIL ack_timeout: byte %h got no ack, want ack within 20 cycles", b);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        lat_bad = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; HALT_flag = 1'b1; packet_ready = 1'b0; uart_packet = 8'h00;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({packet_ack, mem_we, load_busy, load_done, load_error} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {packet_ack, mem_we, load_busy, load_done, load_error});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata} !== 24'h0)
            $display("FAIL reset_bus: got %h want 000000", {mem_addr, mem_wdata});
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_handshake();
        ack_cnt = 0;
        clear_log();
        packet_ready = 1'b1;
        uart_packet  = 8'h12;
        @(negedge clk);        // consumed at the edge before this
        @(negedge clk);        // ready held through the ack cycle
        packet_ready = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (ack_cnt !== 1) $display("FAIL hs_ack_count: got %0d want 1", ack_cnt);
        else pass_cnt++;
        total_cnt++;
        if (load_busy !== 1'b0 || wr_addr.size() != 0)
            $display("FAIL hs_no_state_change: busy %b writes %0d want 0 0", load_busy, wr_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_good_frame();
        clear_log();
        send_byte(8'hA5);
        total_cnt++;
        if (load_busy !== 1'b1) $display("FAIL good_busy: got %b want 1", load_busy);
        else pass_cnt++;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
        // 00^02^34^12^CD^AB = 42
        send_byte(8'h42);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 2) $display("FAIL good_wr_count: got %0d want 2", wr_addr.size());
        else pass_cnt++;
        if (wr_addr.size() == 2) begin
            total_cnt++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1234)
                $display("FAIL good_wr0: got %h/%h want 00/1234", wr_addr[0], wr_data[0]);
            else pass_cnt++;
            total_cnt++;
            if (wr_addr[1] !== 8'd1 || wr_data[1] !== 16'hABCD)
                $display("FAIL good_wr1: got %h/%h want 01/abcd", wr_addr[1], wr_data[1]);
            else pass_cnt++;
        end
        total_cnt++;
        if (lat_bad != 0) $display("FAIL good_wr_latency: got %0d late writes want 0", lat_bad);
        else pass_cnt++;
        total_cnt++;
        if ({load_done, load_error, load_busy} !== 3'b100)
            $display("FAIL good_status: got %b want 100", {load_done, load_error, load_busy});
        else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        clear_log();
        send_byte(8'hA5);
        total_cnt++;
        if (load_done !== 1'b0) $display("FAIL bad_done_cleared: got %b want 0", load_done);
        else pass_cnt++;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
        send_byte(8'h41);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 2) $display("FAIL bad_wr_count: got %0d want 2", wr_addr.size());
        else pass_cnt++;
        total_cnt++;
        if ({load_done, load_error, load_busy} !== 3'b010)
            $display("FAIL bad_status: got %b want 010", {load_done, load_error, load_busy});
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        clear_log();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({load_done, load_error} !== 2'b10 || wr_addr.size() != 0)
            $display("FAIL zero_len: got done/err %b writes %0d want 10 0", {load_done, load_error}, wr_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_oversize();
        clear_log();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        total_cnt++;
        if ({load_done, load_error, load_busy} !== 3'b010)
            $display("FAIL oversize_status: got %b want 010", {load_done, load_error, load_busy});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 0) $display("FAIL oversize_writes: got %0d want 0", wr_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_abort();
        // HALT low with no frame: flags from the oversize frame must hold
        HALT_flag = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({load_done, load_error} !== 2'b01)
            $display("FAIL halt_holds_flags: got %b want 01", {load_done, load_error});
        else pass_cnt++;
        HALT_flag = 1'b1;
        clear_log();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD);
        HALT_flag = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 1) $display("FAIL abort_wr_count: got %0d want 1", wr_addr.size());
        else pass_cnt++;
        total_cnt++;
        if ({load_busy, load_done, load_error, packet_ack, mem_we} !== 5'b0)
            $display("FAIL abort_status: got %b want 00000", {load_busy, load_done, load_error, packet_ack, mem_we});
        else pass_cnt++;
        HALT_flag = 1'b1;
        clear_log();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'hAB);
        send_byte(8'h42);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (load_done !== 1'b1 || wr_addr.size() != 2)
            $display("FAIL abort_resend: got done %b writes %0d want 1 2", load_done, wr_addr.size());
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        clear_log();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h34);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({packet_ack, mem_we, load_busy, load_done, load_error} !== 5'b0 || {mem_addr, mem_wdata} !== 24'h0)
            $display("FAIL async_reset: got %b %h want 00000 000000",
                     {packet_ack, mem_we, load_busy, load_done, load_error}, {mem_addr, mem_wdata});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h00); send_byte(8'h01);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (load_busy !== 1'b0 || wr_addr.size() != 0)
            $display("FAIL garbage_ignored: got busy %b writes %0d want 0 0", load_busy, wr_addr.size());
        else pass_cnt++;
        // 00^01^78^56 = 2F
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h2F);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 1 || load_done !== 1'b1)
            $display("FAIL post_reset_frame: got writes %0d done %b want 1 1", wr_addr.size(), load_done);
        else begin
            pass_cnt++;
            total_cnt++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h5678)
                $display("FAIL post_reset_wr: got %h/%h want 00/5678", wr_addr[0], wr_data[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] lo;
        clear_log();
        // word i = {~i, i}: each pair XORs to FF, 256 pairs cancel, CHK = 01^00
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            lo = 8'(i);
            send_byte(lo);
            send_byte(~lo);
        end
        send_byte(8'h01);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (wr_addr.size() != 256 || {load_done, load_error} !== 2'b10)
            $display("FAIL wrap_count: got writes %0d status %b want 256 10", wr_addr.size(), {load_done, load_error});
        else begin
            pass_cnt++;
            total_cnt++;
            if (wr_addr[0] !== 8'h00 || wr_data[0] !== 16'hFF00 ||
                wr_addr[255] !== 8'hFF || wr_data[255] !== 16'h00FF)
                $display("FAIL wrap_ends: got %h/%h %h/%h want 00/ff00 ff/00ff",
                         wr_addr[0], wr_data[0], wr_addr[255], wr_data[255]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_good_frame();
        test_bad_checksum();
        test_zero_len();
        test_oversize();
        test_abort();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
